r5fp_int_mul_add_seq: RTL and testbench
=======================================

Name: r5fp_int_mul_add_seq

Overview:
Iterative unsigned integer multiply-add unit. It computes P = A*B + C, or P = A*A + C in square mode. It is the inverse-direction companion of R5FP_int_div_sqrt: for a divide result it reconstructs N from Quo*D + Rem, and for a root result it reconstructs the radicand from Root*Root + Rem. It uses the same strobe/done/ready handshake as the divider. It sits beside the divider in the FPU integer datapath and is also reused in verification environments as a hardware reconstruction checker.

Parameters:
W, 10, operand width in bits. P is 2W bits wide. Legal range is W >= 2.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
A_i  input  W  multiplicand (Quo or Root).
B_i  input  W  multiplier (D); ignored when is_sqr_i=1.
C_i  input  W  addend (Rem), zero-extended to 2W bits.
is_sqr_i  input  1  1 = compute A*A + C; 0 = compute A*B + C.
strobe_i  input  1  start request; sampled only while ready_o=1.
P_o  output  2W  result; held stable from the done_o cycle until the next accepted strobe completes.
done_o  output  1  single-cycle pulse: P_o is valid.
ready_o  output  1  1 = idle, next strobe_i will be accepted.

Behaviour:
- Reset: the synchronous, active-high reset is already decided and fixed.
  - reset=1 at a posedge forces state IDLE, ready_o=1, done_o=0, P_o=0, and clears all internal registers.
  - Reset overrides strobe_i and aborts any operation in progress; no done_o pulse is produced for the aborted operation.
- States: IDLE, RUN, FIN.
- IDLE (ready_o=1): on a posedge with strobe_i=1:
  - latch mcand = {W zeros, A_i} (2W bits);
  - latch mplier = is_sqr_i ? A_i : B_i;
  - set acc = {W zeros, C_i} and cnt = 0;
  - set ready_o = 0 and go to RUN.
  - Without a strobe, stay in IDLE.
- RUN: each posedge:
  - if mplier[0], then acc += mcand (2W-bit add);
  - mcand <<= 1, mplier >>= 1, cnt += 1;
  - after the edge where cnt reaches W-1 (the W-th iteration), go to FIN.
- FIN: on one posedge:
  - P_o <= acc, done_o <= 1, ready_o <= 1;
  - go to IDLE.
  - done_o deasserts at the following posedge unless a new operation finishes there, which cannot happen.
- Latency: strobe accepted at edge k; done_o=1 and P_o valid in the cycle after edge k+W+1.
- Throughput: one operation per W+2 cycles.
- Early termination is not permitted. Latency is fixed regardless of operand values, because the bench and divider-side sequencers count on it.
- Strobe while busy (ready_o=0): ignored, with no queueing and no effect on the current operation.
- Strobe in the done_o cycle: ready_o=1 there, so the strobe is accepted. done_o drops next cycle, and P_o keeps its old value until the new FIN.
- Operands are sampled only at acceptance. Later input changes have no effect.
- Width rule: the maximum result is (2^W-1)^2 + (2^W-1) = 2^2W - 2^W. It always fits in 2W bits, so no overflow flag is needed and no carry is dropped.
- Zero operands: A=0 or B=0 gives P=C. C=0 gives the pure product.
- cnt width: $clog2(W) bits, with no wrap before W-1.

Decomposition:
- Shared package r5fp_int_pkg holds:
  - enum typedef int_seq_state_t {IDLE, RUN, FIN};
  - localparam helper for the cnt width.
  - The divider's sequencer uses the same enum.
- One natural sub-module, r5fp_mul_step: combinational single iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier.
  - Parameterised by W.
- The top level contains the FSM, counter and handshake registers.

Test Plan:
- Reset then idle: after reset, ready_o=1, done_o=0, P_o=0. No strobe for 20 cycles leaves the outputs unchanged.
- Basic MAC (W=10): A=37, B=27, C=13, is_sqr=0, strobe at edge k → done_o pulses exactly one cycle after edge k+11, P_o=1012, ready_o returns to 1 in the same cycle.
- Square mode, with B_i=1023 as garbage: A=31, C=62, is_sqr=1 → P_o=1023 (reconstructs isqrt(1023)=31, rem 62).
- Extremes: A=B=C=1023 → P_o=1047552 (2^20-2^10); A=0, B=500, C=7 → P_o=7.
- Busy/back-to-back:
  - strobe held high continuously → accepted every W+2=12 cycles;
  - strobe pulses mid-RUN are ignored;
  - changing A_i mid-RUN does not alter the result.
- Reset mid-RUN, at edge k+5: no done_o pulse, P_o=0, ready_o=1 next cycle. A new strobe then completes normally with correct latency.
- Exhaustive W=10 divider-consistency sweep: for every D in 1..1023 and N in 1..D, feed Quo=N/D, Rem=N%D → P_o[W-1:0]=N.

Source files
------------

// File: rtl/r5fp_int_pkg.sv
// rtl/r5fp_int_pkg.sv - shared types and helpers for the integer sequencers
package r5fp_int_pkg;

    // Sequencer state shared by the multiply-add and divide/sqrt units
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } int_seq_state_t;

    // Iteration counter width: must hold 0..W-1 without wrapping
    function automatic int int_seq_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/r5fp_mul_step.sv
// rtl/r5fp_mul_step.sv - one shift-add multiply iteration
module r5fp_mul_step #(
    parameter int W = 10
) (
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] acc_nxt,
    output logic [2*W-1:0] mcand_nxt,
    output logic [W-1:0]   mplier_nxt
);

    // Add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/r5fp_int_mul_add_seq.sv
// rtl/r5fp_int_mul_add_seq.sv - iterative unsigned P = A*B + C (or A*A + C)
module r5fp_int_mul_add_seq
    import r5fp_int_pkg::*;
#(
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   A_i,
    input  logic [W-1:0]   B_i,
    input  logic [W-1:0]   C_i,
    input  logic           is_sqr_i,
    input  logic           strobe_i,
    output logic [2*W-1:0] P_o,
    output logic           done_o,
    output logic           ready_o
);

    localparam int CW = int_seq_cnt_w(W);

    int_seq_state_t state, state_n;

    logic [2*W-1:0] acc, mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] acc_nxt, mcand_nxt;
    logic [W-1:0]   mplier_nxt;

    logic load, step_en, finish, last_iter;

    assign last_iter = (cnt == CW'(W - 1));

    r5fp_mul_step #(.W(W)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: fixed W iterations in RUN, never terminate early
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (strobe_i)  state_n = RUN;
            RUN:     if (last_iter) state_n = FIN;
            FIN:                    state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    // Handshake and datapath controls decoded from state
    always_comb begin
        ready_o = (state == IDLE);
        load    = (state == IDLE) && strobe_i;
        step_en = (state == RUN);
        finish  = (state == FIN);
    end

    // Operand capture at acceptance, then one shift-add per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{W{1'b0}}, A_i};
            mplier <= is_sqr_i ? A_i : B_i;
            acc    <= {{W{1'b0}}, C_i};
            cnt    <= '0;
        end else if (step_en) begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result register: P_o holds until the next operation's FIN
    always_ff @(posedge clk) begin
        if (reset) begin
            P_o    <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= finish;
            if (finish) P_o <= acc;
        end
    end

endmodule

// File: tb/tb_r5fp_int_mul_add_seq.sv
// tb/tb_r5fp_int_mul_add_seq.sv - randomized self-checking bench with behavioural model
module tb_r5fp_int_mul_add_seq;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   a, b, c;
    logic           sqr, strobe;
    logic [2*W-1:0] p;
    logic           done, ready;

    always #5 clk = ~clk;

    r5fp_int_mul_add_seq #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A_i      (a),
        .B_i      (b),
        .C_i      (c),
        .is_sqr_i (sqr),
        .strobe_i (strobe),
        .P_o      (p),
        .done_o   (done),
        .ready_o  (ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // Behavioural model: an accepted operation yields a*b+c exactly W+1 edges later
    longint unsigned m_pending = 0;
    longint unsigned m_p       = 0;
    int              m_remain  = 0;
    bit              m_done    = 0;
    bit              m_ready   = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_remain = 0;
            m_p      = 0;
            m_done   = 0;
            m_ready  = 1;
        end else begin
            m_done = 0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_p     = m_pending;
                    m_done  = 1;
                    m_ready = 1;
                end
            end else if (m_ready && strobe) begin
                m_pending = longint'(a) * longint'(sqr ? a : b) + longint'(c);
                m_remain  = W + 1;
                m_ready   = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_o", 64'(ready), 64'(m_ready));
            chk("done_o",  64'(done),  64'(m_done));
            chk("P_o",     64'(p),     m_p);
        end
    end

    task automatic run_op(input int av, input int bv, input int cv, input bit sv,
                          input longint unsigned expv);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("ready_wait", 64'(ready), 64'd1);
        a = W'(av); b = W'(bv); c = W'(cv); sqr = sv; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); sqr = 1'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(W + 1));
        chk("result",  64'(p), expv);
        chk("model",   m_p,    expv);
        chk("ready_at_done", 64'(ready), 64'd1);
    endtask

    initial begin
        int done_cycles[$];
        int d, nn;
        reset = 1'b1; strobe = 1'b0; a = '0; b = '0; c = '0; sqr = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_p",     64'(p),     64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd1);
        chk("idle_p",     64'(p),     64'd0);

        run_op(37, 27, 13, 1'b0, 64'd1012);
        run_op(31, 1023, 62, 1'b1, 64'd1023);
        run_op(1023, 1023, 1023, 1'b0, 64'd1047552);
        run_op(0, 500, 7, 1'b0, 64'd7);
        run_op(25, 40, 0, 1'b0, 64'd1000);

        // Strobe held high with inputs changing every cycle
        repeat (2) @(negedge clk);
        strobe = 1'b1;
        for (int i = 0; i < 62; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom); sqr = 1'($urandom);
            @(negedge clk);
            if (done === 1'b1) done_cycles.push_back(cyc);
        end
        strobe = 1'b0;
        chk("held_count", 64'(done_cycles.size() >= 4), 64'd1);
        for (int i = 1; i < done_cycles.size(); i++)
            chk("held_period", 64'(done_cycles[i] - done_cycles[i-1]), 64'(W + 2));
        repeat (15) @(negedge clk);

        // Reset at edge k+5 aborts the operation
        a = 10'd100; b = 10'd200; c = 10'd3; sqr = 1'b0; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_p",     64'(p),     64'd0);
        repeat (15) @(negedge clk);
        chk("abort_nodone", 64'(done), 64'd0);
        run_op(100, 200, 3, 1'b0, 64'd20003);

        // Random strobes, inputs and occasional resets
        for (int i = 0; i < 2000; i++) begin
            strobe = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            a = W'($urandom); b = W'($urandom); c = W'($urandom); sqr = 1'($urandom);
            @(negedge clk);
        end
        strobe = 1'b0; reset = 1'b0;
        repeat (15) @(negedge clk);

        // Divider-consistency sweep: Quo*D + Rem reconstructs N
        run_op(1, 1, 0, 1'b0, 64'd1);
        run_op(1, 1023, 0, 1'b0, 64'd1023);
        run_op(0, 1023, 1022, 1'b0, 64'd1022);
        for (int i = 0; i < 1200; i++) begin
            d  = $urandom_range(1, 1023);
            nn = $urandom_range(1, d);
            run_op(nn / d, d, nn % d, 1'b0, 64'(nn));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
